// File: rtl/usb_rx_deframer.sv
// Full-speed USB receive deframer: NRZI decode, SYNC hunt, bit unstuffing, LSB-first byte
// assembly and EOP handling, presenting one-cycle byte beats with a one-byte hold for eop tagging.
module usb_rx_deframer #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int STUFF_LEN      = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_bit_en_i,
  input  logic       rx_dp_i,
  input  logic       rx_dm_i,
  output logic       rx_lp_sop_o,
  output logic       rx_lp_eop_o,
  output logic       rx_lp_valid_o,
  input  logic       rx_lp_ready_i,
  output logic [7:0] rx_lp_data_o,
  output logic       rx_active_o,
  output logic       rx_err_o,
  output logic       rx_ovf_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_EOP   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0] state_q, state_d;
  logic       prev_j_q, prev_j_d;
  logic [2:0] zcnt_q, zcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       first_q, first_d;
  logic       se0_seen_q, se0_seen_d;
  logic       active_q, active_d;
  logic       valid_q, valid_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;

  logic       is_j, is_k, is_se0, is_jk, dbit;
  logic [7:0] new_byte;

  assign is_j     = rx_dp_i & ~rx_dm_i;
  assign is_k     = ~rx_dp_i & rx_dm_i;
  assign is_se0   = ~rx_dp_i & ~rx_dm_i;
  assign is_jk    = is_j | is_k;
  assign dbit     = (is_j == prev_j_q);
  assign new_byte = {dbit, shift_q[7:1]};

  always_comb begin
    state_d     = state_q;
    prev_j_d    = prev_j_q;
    zcnt_d      = zcnt_q;
    ones_d      = ones_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    first_d     = first_q;
    se0_seen_d  = se0_seen_q;
    active_d    = active_q;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    data_d      = 8'h00;
    err_d       = 1'b0;
    if (rx_bit_en_i) begin
      if (is_jk) prev_j_d = is_j;
      case (state_q)
        S_IDLE: if (is_k) begin
          state_d = S_SYNC;
          zcnt_d  = 3'd1;
        end
        S_SYNC: begin
          if (!is_jk) state_d = S_IDLE;
          else if (!dbit) begin
            if (zcnt_q != 3'd7) zcnt_d = zcnt_q + 3'd1;
          end else if (zcnt_q >= 3'(SYNC_MIN_ZEROS)) begin
            // the terminating 1 of SYNC already counts toward the stuffing run
            state_d     = S_DATA;
            active_d    = 1'b1;
            ones_d      = 3'd1;
            bcnt_d      = 3'd0;
            hold_full_d = 1'b0;
            first_d     = 1'b1;
          end else state_d = S_IDLE;
        end
        S_DATA: begin
          if (is_jk) begin
            if (ones_q == 3'(STUFF_LEN)) begin
              ones_d = 3'd0;
              if (dbit) begin
                err_d       = 1'b1;
                hold_full_d = 1'b0;
                se0_seen_d  = 1'b0;
                state_d     = S_ABORT;
              end
            end else begin
              shift_d = new_byte;
              ones_d  = dbit ? ones_q + 3'd1 : 3'd0;
              bcnt_d  = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                if (hold_full_q) begin
                  valid_d = 1'b1;
                  data_d  = hold_q;
                  sop_d   = first_q;
                  first_d = 1'b0;
                end
                hold_d      = new_byte;
                hold_full_d = 1'b1;
              end
            end
          end else if (is_se0) begin
            if (hold_full_q) begin
              valid_d = 1'b1;
              data_d  = hold_q;
              sop_d   = first_q;
              eop_d   = 1'b1;
            end
            if (bcnt_q != 3'd0 || !hold_full_q) err_d = 1'b1;
            hold_full_d = 1'b0;
            state_d     = S_EOP;
          end else begin
            err_d       = 1'b1;
            hold_full_d = 1'b0;
            se0_seen_d  = 1'b0;
            state_d     = S_ABORT;
          end
        end
        S_EOP: begin
          if (is_j) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end else if (!is_se0) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end
        S_ABORT: begin
          if (is_se0) se0_seen_d = 1'b1;
          else if (is_j && se0_seen_q) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end else se0_seen_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      prev_j_q    <= 1'b1;
      zcnt_q      <= 3'd0;
      ones_q      <= 3'd0;
      bcnt_q      <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      se0_seen_q  <= 1'b0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_j_q    <= prev_j_d;
      zcnt_q      <= zcnt_d;
      ones_q      <= ones_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      first_q     <= first_d;
      se0_seen_q  <= se0_seen_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign rx_lp_valid_o = valid_q;
  assign rx_lp_sop_o   = sop_q;
  assign rx_lp_eop_o   = eop_q;
  assign rx_lp_data_o  = data_q;
  assign rx_active_o   = active_q;
  assign rx_err_o      = err_q;
  // no backpressure: a beat offered while the consumer stalls is simply flagged
  assign rx_ovf_o      = valid_q & ~rx_lp_ready_i;

endmodule

// File: tb/tb_usb_rx_deframer.sv
// Bench for usb_rx_deframer: encodes byte lists onto the wire (stuffing + NRZI) and compares
// the resulting beats against the byte lists, plus directed error/reset/overflow cases.
module tb_usb_rx_deframer;
  logic       clk = 1'b0;
  logic       rst, en, dp, dm, ready;
  logic       sop, eop, valid, active, err, ovf;
  logic [7:0] data;

  usb_rx_deframer dut (
    .clk_i(clk), .rst_i(rst), .rx_bit_en_i(en), .rx_dp_i(dp), .rx_dm_i(dm),
    .rx_lp_sop_o(sop), .rx_lp_eop_o(eop), .rx_lp_valid_o(valid), .rx_lp_ready_i(ready),
    .rx_lp_data_o(data), .rx_active_o(active), .rx_err_o(err), .rx_ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic s; logic e; logic [7:0] d; } beat_t;
  beat_t beats[$];
  int nchk = 0, nerr = 0, errs = 0, ovfs = 0, dirty = 0;
  bit lvl;
  int ones;

  always @(negedge clk) begin
    if (valid) beats.push_back('{sop, eop, data});
    else if (sop || eop || data != 8'h00) dirty++;
    if (err) errs++;
    if (ovf) ovfs++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sym(input bit p, input bit m);
    dp = p; dm = m; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic nbit(input bit b);
    if (!b) lvl = ~lvl;
    sym(lvl, ~lvl);
  endtask

  task automatic dbit(input bit b);
    nbit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin nbit(1'b0); ones = 0; end
  endtask

  task automatic sync_seq(input int nz);
    for (int i = 0; i < nz; i++) nbit(1'b0);
    nbit(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) dbit(b[i]);
  endtask

  task automatic eop_seq();
    sym(1'b0, 1'b0); sym(1'b0, 1'b0);
    lvl = 1'b1; sym(1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pkt(input int nz, input logic [7:0] q[$]);
    sync_seq(nz);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] q[$], input int exp_err, input int exp_ovf);
    chk({tag, ".nbeats"}, beats.size(), q.size());
    for (int i = 0; i < q.size() && i < beats.size(); i++) begin
      chk({tag, ".data"}, beats[i].d, q[i]);
      chk({tag, ".sop"}, beats[i].s, i == 0);
      chk({tag, ".eop"}, beats[i].e, i == q.size() - 1);
    end
    chk({tag, ".err"}, errs, exp_err);
    chk({tag, ".ovf"}, ovfs, exp_ovf);
    chk({tag, ".idle_active"}, active, 0);
    beats.delete(); errs = 0; ovfs = 0;
  endtask

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; en = 1'b0; dp = 1'b1; dm = 1'b0; ready = 1'b1;
    lvl = 1'b1; ones = 0;
    repeat (3) @(negedge clk);
    chk("rst.valid", valid, 0); chk("rst.active", active, 0);
    chk("rst.err", err, 0); chk("rst.data", data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ACK
    q = '{8'hD2};
    send_pkt(7, q);
    chk("ack.active", active, 1);
    eop_seq();
    check_pkt("ack", q, 0, 0);

    // stuffing across bytes
    q = '{8'hC3, 8'hFF, 8'hFF};
    send_pkt(7, q); eop_seq();
    check_pkt("stuff", q, 0, 0);

    // stuff violation after PID: abort, held PID never emitted
    q = '{8'h4B};
    send_pkt(7, q);
    repeat (7) nbit(1'b1);
    chk("stufferr.active", active, 1);
    eop_seq();
    q = {};
    check_pkt("stufferr", q, 1, 0);

    // misaligned EOP
    q = '{8'h5A};
    send_pkt(7, q);
    dbit(1'b1); dbit(1'b0); dbit(1'b1);
    eop_seq();
    check_pkt("misalign", q, 1, 0);

    // reset after two bytes of a three-byte packet
    q = '{8'h11, 8'h22};
    send_pkt(7, q);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("midrst.valid", valid, 0); chk("midrst.sop", sop, 0); chk("midrst.eop", eop, 0);
    chk("midrst.data", data, 0); chk("midrst.active", active, 0);
    chk("midrst.err", err, 0); chk("midrst.ovf", ovf, 0);
    send_byte(8'h33);
    eop_seq();
    chk("midrst.nbeats", beats.size(), 1);
    if (beats.size() > 0) begin
      chk("midrst.data0", beats[0].d, 8'h11);
      chk("midrst.sop0", beats[0].s, 1);
      chk("midrst.eop0", beats[0].e, 0);
    end
    chk("midrst.errs", errs, 0);
    beats.delete(); errs = 0; ovfs = 0;
    q = '{8'hD2};
    send_pkt(7, q); eop_seq();
    check_pkt("postrst", q, 0, 0);

    // overflow on a stalled consumer
    ready = 1'b0;
    send_pkt(7, q); eop_seq();
    ready = 1'b1;
    check_pkt("ovf", q, 0, 1);

    // short SYNC is ignored silently
    sync_seq(3);
    lvl = 1'b1;
    repeat (3) sym(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    q = {};
    check_pkt("shortsync", q, 0, 0);

    // random packets, SYNC with 5..8 leading zeros, bytes biased toward 0xFF
    for (int p = 0; p < 24; p++) begin
      int n;
      n = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      send_pkt($urandom_range(5, 8), q);
      eop_seq();
      check_pkt("rand", q, 0, 0);
    end

    chk("dirty_outputs", dirty, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
